// File: rtl/ddr3_wburst_seq.sv
// Write-burst sequencer for one DDR3 byte lane: drives DQS/DQ serializer words for preamble, BL8 bursts and postamble.
// Optional ODT output enabled by defining DDR3_WBURST_ODT_EN.
module ddr3_wburst_seq #(
    parameter int WLAT_WIDTH = 4,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk_div,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WLAT_WIDTH-1:0] cmd_wlat,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic [3:0]            dqs_din,
    output logic [3:0]            dqs_tin,
    output logic [3:0]            dq_tin,
    output logic                  data_rd,
    output logic                  busy,
    output logic                  done
`ifdef DDR3_WBURST_ODT_EN
    ,
    output logic                  odt
`endif
);

    // One counter serves both the write-latency wait and the DATA cycle count.
    localparam int CW = (LEN_WIDTH + 1 > WLAT_WIDTH) ? LEN_WIDTH + 1 : WLAT_WIDTH;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_PRE, S_DATA, S_POST} state_t;

    state_t                r_state, w_nstate;
    logic [CW-1:0]         r_cnt, w_ncnt;
    logic [WLAT_WIDTH-1:0] r_wlat, w_nwlat;
    logic [LEN_WIDTH-1:0]  r_len, w_nlen;
    logic                  r_pend, w_npend;
    logic                  w_acc;

    logic                  r_ready, r_busy, r_done, r_rd;
    logic [3:0]            r_dqs_din, r_dqs_tin, r_dq_tin;
    logic                  w_ready, w_busy, w_done, w_rd;
    logic [3:0]            w_dqs_din, w_dqs_tin, w_dq_tin;
    logic                  r_odt, w_odt;

    assign w_acc = cmd_valid & r_ready;

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_wlat    <= '0;
            r_len     <= '0;
            r_pend    <= 1'b0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd      <= 1'b0;
            r_dqs_din <= 4'b0000;
            r_dqs_tin <= 4'b1111;
            r_dq_tin  <= 4'b1111;
            r_odt     <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_cnt     <= w_ncnt;
            r_wlat    <= w_nwlat;
            r_len     <= w_nlen;
            r_pend    <= w_npend;
            r_ready   <= w_ready;
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_rd      <= w_rd;
            r_dqs_din <= w_dqs_din;
            r_dqs_tin <= w_dqs_tin;
            r_dq_tin  <= w_dq_tin;
            r_odt     <= w_odt;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ncnt   = r_cnt;
        w_nwlat  = r_wlat;
        w_nlen   = r_len;
        w_npend  = r_pend;
        case (r_state)
            S_IDLE: begin
                w_ncnt = '0;
                if (w_acc) begin
                    w_nwlat = cmd_wlat;
                    w_nlen  = cmd_len;
                    if (cmd_wlat == '0) begin
                        w_nstate = S_PRE;
                    end else begin
                        w_nstate = S_WAIT;
                        w_ncnt   = CW'(cmd_wlat) - CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) w_nstate = S_PRE;
                else             w_ncnt   = r_cnt - CW'(1);
            end
            S_PRE: begin
                w_nstate = S_DATA;
                w_ncnt   = CW'({r_len, 1'b1});
            end
            S_DATA: begin
                if (r_cnt != '0) begin
                    w_ncnt = r_cnt - CW'(1);
                end else if (w_acc) begin
                    w_nwlat = cmd_wlat;
                    w_nlen  = cmd_len;
                    // wlat=0 continues seamlessly; otherwise close this burst and reopen after POST
                    if (cmd_wlat == '0) begin
                        w_ncnt = CW'({cmd_len, 1'b1});
                    end else begin
                        w_nstate = S_POST;
                        w_npend  = 1'b1;
                    end
                end else begin
                    w_nstate = S_POST;
                end
            end
            S_POST: begin
                w_npend = 1'b0;
                w_ncnt  = '0;
                if (!r_pend) begin
                    w_nstate = S_IDLE;
                end else if (r_wlat == WLAT_WIDTH'(1)) begin
                    w_nstate = S_PRE;
                end else begin
                    w_nstate = S_WAIT;
                    w_ncnt   = CW'(r_wlat) - CW'(2);
                end
            end
            default: begin
                w_nstate = S_IDLE;
                w_ncnt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered value lines up with the state it describes.
    always_comb begin
        w_ready   = 1'b0;
        w_busy    = (w_nstate != S_IDLE);
        w_done    = 1'b0;
        w_rd      = 1'b0;
        w_dqs_din = 4'b0000;
        w_dqs_tin = 4'b1111;
        w_dq_tin  = 4'b1111;
        w_odt     = 1'b0;
        case (w_nstate)
            S_IDLE: w_ready = 1'b1;
            S_PRE: begin
                w_dqs_tin = 4'b1100;
                w_odt     = 1'b1;
            end
            S_DATA: begin
                w_ready   = (w_ncnt == '0);
                w_rd      = 1'b1;
                w_dqs_din = 4'b0101;
                w_dqs_tin = 4'b0000;
                w_dq_tin  = 4'b0000;
                w_odt     = 1'b1;
            end
            S_POST: begin
                w_done    = 1'b1;
                w_dqs_tin = 4'b0011;
                w_odt     = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign data_rd   = r_rd;
    assign dqs_din   = r_dqs_din;
    assign dqs_tin   = r_dqs_tin;
    assign dq_tin    = r_dq_tin;
`ifdef DDR3_WBURST_ODT_EN
    assign odt       = r_odt;
`else
    logic w_odt_unused;
    assign w_odt_unused = r_odt;
`endif

endmodule

// File: tb/tb_ddr3_wburst_seq.sv
// Directed self-checking bench for ddr3_wburst_seq; checks the full output word every cycle against per-state constants.
module tb_ddr3_wburst_seq;

    logic       clk_div = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_wlat;
    logic [3:0] cmd_len;
    logic [3:0] dqs_din, dqs_tin, dq_tin;
    logic       data_rd, busy, done;
`ifdef DDR3_WBURST_ODT_EN
    logic       odt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int rd_cnt;

    localparam int S_IDLE = 0, S_WAIT = 1, S_PRE = 2, S_DATA = 3, S_LAST = 4, S_POST = 5, S_RST = 6;

    ddr3_wburst_seq #(.WLAT_WIDTH(4), .LEN_WIDTH(4)) dut (
        .clk_div   (clk_div),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_wlat  (cmd_wlat),
        .cmd_len   (cmd_len),
        .dqs_din   (dqs_din),
        .dqs_tin   (dqs_tin),
        .dq_tin    (dq_tin),
        .data_rd   (data_rd),
        .busy      (busy),
        .done      (done)
`ifdef DDR3_WBURST_ODT_EN
        ,
        .odt       (odt)
`endif
    );

    always #5 clk_div = ~clk_div;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {cmd_ready, busy, done, data_rd, dqs_din, dqs_tin, dq_tin}
    function automatic logic [15:0] exp_vec(input int st);
        case (st)
            S_IDLE:  return 16'h80FF;
            S_WAIT:  return 16'h40FF;
            S_PRE:   return 16'h40CF;
            S_DATA:  return 16'h5500;
            S_LAST:  return 16'hD500;
            S_POST:  return 16'h603F;
            default: return 16'h00FF;
        endcase
    endfunction

    task automatic exp_st(input string tag, input int st);
        chk(tag, {16'h0, cmd_ready, busy, done, data_rd, dqs_din, dqs_tin, dq_tin}, {16'h0, exp_vec(st)});
`ifdef DDR3_WBURST_ODT_EN
        chk({tag, "_odt"}, {31'h0, odt},
            {31'h0, (st == S_PRE || st == S_DATA || st == S_LAST || st == S_POST)});
`endif
    endtask

    task automatic step();
        @(posedge clk_div);
        #1;
    endtask

    task automatic issue(input logic [3:0] w, input logic [3:0] l);
        cmd_valid = 1'b1;
        cmd_wlat  = w;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_wlat = '0; cmd_len = '0;
        #2;
        exp_st("rst_hold", S_RST);
        step(); step();
        exp_st("rst_hold2", S_RST);
        rst = 1'b0;
        step();
        exp_st("idle_after_rst", S_IDLE);

        // wlat=2, len=0
        issue(4'd2, 4'd0);
        exp_st("t1_wait1", S_WAIT);
        step(); exp_st("t1_wait2", S_WAIT);
        step(); exp_st("t1_pre", S_PRE);
        step(); exp_st("t1_data1", S_DATA);
        step(); exp_st("t1_data2", S_LAST);
        step(); exp_st("t1_post", S_POST);
        step(); exp_st("t1_idle", S_IDLE);

        // wlat=0, len=3: eight data_rd cycles, ready only in the last
        issue(4'd0, 4'd3);
        exp_st("t2_pre", S_PRE);
        rd_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            rd_cnt += int'(data_rd);
            exp_st($sformatf("t2_data%0d", i), (i == 7) ? S_LAST : S_DATA);
        end
        chk("t2_rd_cnt", rd_cnt, 8);
        step(); exp_st("t2_post", S_POST);
        step(); exp_st("t2_idle", S_IDLE);

        // seamless back-to-back with wlat=0
        issue(4'd0, 4'd0);
        exp_st("t3_pre", S_PRE);
        step(); exp_st("t3_a_data", S_DATA);
        step(); exp_st("t3_a_last", S_LAST);
        issue(4'd0, 4'd1);
        exp_st("t3_b_data1", S_DATA);
        step(); exp_st("t3_b_data2", S_DATA);
        step(); exp_st("t3_b_data3", S_DATA);
        step(); exp_st("t3_b_last", S_LAST);
        step(); exp_st("t3_post", S_POST);
        step(); exp_st("t3_idle", S_IDLE);

        // second command with wlat=1 accepted in the last DATA cycle
        issue(4'd0, 4'd0);
        exp_st("t4_pre", S_PRE);
        step(); exp_st("t4_a_data", S_DATA);
        step(); exp_st("t4_a_last", S_LAST);
        issue(4'd1, 4'd0);
        exp_st("t4_post_gap", S_POST);
        step(); exp_st("t4_pre_gap", S_PRE);
        step(); exp_st("t4_b_data", S_DATA);
        step(); exp_st("t4_b_last", S_LAST);
        step(); exp_st("t4_post", S_POST);
        step(); exp_st("t4_idle", S_IDLE);

        // asynchronous reset mid-burst
        issue(4'd0, 4'd3);
        exp_st("t5_pre", S_PRE);
        step(); exp_st("t5_data1", S_DATA);
        step(); exp_st("t5_data2", S_DATA);
        #2 rst = 1'b1;
        #1 exp_st("t5_async_rst", S_RST);
        step(); exp_st("t5_rst_edge", S_RST);
        rst = 1'b0;
        step(); exp_st("t5_idle", S_IDLE);

        // maximum write latency: PRE 16 cycles after acceptance
        issue(4'd15, 4'd0);
        for (int i = 1; i <= 15; i++) begin
            exp_st($sformatf("t6_wait%0d", i), S_WAIT);
            step();
        end
        exp_st("t6_pre", S_PRE);
        step(); exp_st("t6_data", S_DATA);
        step(); exp_st("t6_last", S_LAST);
        step(); exp_st("t6_post", S_POST);
        step(); exp_st("t6_idle", S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
